// File: rtl/cmd_pkg.sv
// Shared types, field widths, frame constants and byte-selection helper for cmd_serializer.
// Optional frame checksum byte is enabled by defining CMD_CHKSUM_EN.
package cmd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
   localparam int         DTYPE_W        = 4;
   localparam int         OP_W           = 5;
   localparam int         SRC_W          = 16;
   localparam int         IDX_W          = 3;
   localparam int         FRAME_LEN_BASE = 7;
   localparam int         FRAME_LEN_CHK  = 8;

`ifdef CMD_CHKSUM_EN
   localparam int         FRAME_LEN      = FRAME_LEN_CHK;
`else
   localparam int         FRAME_LEN      = FRAME_LEN_BASE;
`endif

   function automatic logic [7:0] frame_byte(
      input logic [IDX_W-1:0]   idx,
      input logic [7:0]         sync,
      input logic [DTYPE_W-1:0] dtype,
      input logic [OP_W-1:0]    op,
      input logic [SRC_W-1:0]   src1,
      input logic [SRC_W-1:0]   src2
   );
      logic [7:0] b;
      case (idx)
         3'd0:    b = sync;
         3'd1:    b = {dtype, 4'h0};
         3'd2:    b = {3'b000, op};
         3'd3:    b = src1[15:8];
         3'd4:    b = src1[7:0];
         3'd5:    b = src2[15:8];
         3'd6:    b = src2[7:0];
`ifdef CMD_CHKSUM_EN
         // Sync byte is deliberately excluded from the checksum.
         3'd7:    b = {dtype, 4'h0} ^ {3'b000, op} ^ src1[15:8] ^ src1[7:0]
                      ^ src2[15:8] ^ src2[7:0];
`endif
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cmd_serializer.sv
// Serializes one command frame per start request into UART bytes with a tx_done handshake.
// Defining CMD_CHKSUM_EN appends an XOR checksum byte (8-byte frame instead of 7).
//
// state | meaning
// IDLE  | waiting for start; fields captured on acceptance
// SEND  | uart_valid pulse with byte[index]
// WAIT  | byte held on uart_out until tx_done
// DONE  | done pulse, frame complete
module cmd_serializer
   import cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic [DTYPE_W-1:0] dtype,
   input  logic [OP_W-1:0]    op,
   input  logic [SRC_W-1:0]   src1,
   input  logic [SRC_W-1:0]   src2,
   output logic [7:0]         uart_out,
   output logic               uart_valid,
   input  logic               tx_done,
   output logic               busy,
   output logic               done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [DTYPE_W-1:0] r_dtype;
   logic [OP_W-1:0]    r_op;
   logic [SRC_W-1:0]   r_src1;
   logic [SRC_W-1:0]   r_src2;
   logic [7:0]         w_byte;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      uart_valid  = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: if (start) w_state_nxt = SEND;
         SEND: begin
            uart_valid  = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: if (tx_done) w_state_nxt = (r_idx == LAST_IDX) ? DONE : SEND;
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_idx   <= '0;
         r_dtype <= '0;
         r_op    <= '0;
         r_src1  <= '0;
         r_src2  <= '0;
      end else if (r_state == IDLE && start) begin
         r_idx   <= '0;
         r_dtype <= dtype;
         r_op    <= op;
         r_src1  <= src1;
         r_src2  <= src2;
      end else if (r_state == WAIT && tx_done && r_idx != LAST_IDX) begin
         r_idx   <= r_idx + 1'b1;
      end
   end

   assign w_byte = frame_byte(r_idx, SYNC_BYTE, r_dtype, r_op, r_src1, r_src2);

   // Byte is only presented while a transfer is in flight so IDLE/DONE read as zero.
   assign uart_out = (r_state == SEND || r_state == WAIT) ? w_byte : 8'h00;
   assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_cmd_serializer.sv
// Randomized and directed self-checking bench for cmd_serializer against a byte-list reference model.
module tb_cmd_serializer;

`ifdef CMD_CHKSUM_EN
   localparam int NBYTES = 8;
`else
   localparam int NBYTES = 7;
`endif

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  dtype = '0;
   logic [4:0]  op = '0;
   logic [15:0] src1 = '0;
   logic [15:0] src2 = '0;
   logic [7:0]  uart_out;
   logic        uart_valid;
   logic        tx_done = 1'b0;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_pass   = 0;

   cmd_serializer dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .dtype      (dtype),
      .op         (op),
      .src1       (src1),
      .src2       (src2),
      .uart_out   (uart_out),
      .uart_valid (uart_valid),
      .tx_done    (tx_done),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference frame: list of bytes, checksum = XOR of everything after the sync byte.
   task automatic build_frame(input logic [3:0] dt, input logic [4:0] o,
                              input logic [15:0] s1, input logic [15:0] s2,
                              output logic [7:0] fr [8]);
      logic [7:0] x;
      fr[0] = 8'hA5;
      fr[1] = 8'(dt * 16);
      fr[2] = 8'(o);
      fr[3] = 8'(s1 / 256);
      fr[4] = 8'(s1 % 256);
      fr[5] = 8'(s2 / 256);
      fr[6] = 8'(s2 % 256);
      x = 8'h00;
      for (int k = 1; k < 7; k++) x = x ^ fr[k];
      fr[7] = x;
   endtask

   task automatic check_idle(input int ncyc, input string tag);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         check({tag, "_valid"}, 32'(uart_valid), 0);
         check({tag, "_busy"}, 32'(busy), 0);
         check({tag, "_done"}, 32'(done), 0);
      end
   endtask

   // Sends one frame; returns at the negedge where done is high (or after a reset abort).
   task automatic send_frame(input logic [3:0] dt, input logic [4:0] o,
                             input logic [15:0] s1, input logic [15:0] s2,
                             input int gap, input int busy_i, input int stray_i,
                             input int rst_i);
      logic [7:0] fr [8];
      int budget;
      build_frame(dt, o, s1, s2, fr);
      @(negedge clk);
      start = 1'b1; dtype = dt; op = o; src1 = s1; src2 = s2;
      @(negedge clk);
      start = 1'b0;
      dtype = 4'($urandom); op = 5'($urandom); src1 = 16'($urandom); src2 = 16'($urandom);
      check("first_valid_latency", 32'(uart_valid), 1);
      check("busy_after_start", 32'(busy), 1);
      for (int i = 0; i < NBYTES; i++) begin
         budget = 0;
         while (!uart_valid && budget < 100) begin
            @(negedge clk);
            budget++;
         end
         check($sformatf("valid_b%0d", i), 32'(uart_valid), 1);
         if (!uart_valid) return;
         check($sformatf("byte_b%0d", i), 32'(uart_out), 32'(fr[i]));
         if (i == busy_i) begin
            start = 1'b1; dtype = 4'($urandom); op = 5'($urandom);
            src1 = 16'($urandom); src2 = 16'($urandom);
         end
         if (i == stray_i) tx_done = 1'b1;
         @(negedge clk);
         start = 1'b0; tx_done = 1'b0;
         check($sformatf("pulse_b%0d", i), 32'(uart_valid), 0);
         if (i == rst_i) begin
            #2 n_rst = 1'b0;
            #1;
            check("rst_uart_out", 32'(uart_out), 0);
            check("rst_valid", 32'(uart_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            @(negedge clk);
            n_rst = 1'b1;
            return;
         end
         for (int k = 1; k < gap; k++) @(negedge clk);
         check($sformatf("hold_b%0d", i), 32'(uart_out), 32'(fr[i]));
         check($sformatf("nodone_b%0d", i), 32'(done), 0);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         if (i == NBYTES - 1) begin
            check("done_pulse", 32'(done), 1);
            check("busy_in_done", 32'(busy), 1);
            check("valid_in_done", 32'(uart_valid), 0);
         end else begin
            check($sformatf("next_valid_b%0d", i + 1), 32'(uart_valid), 1);
         end
      end
   endtask

   initial begin
      #1;
      check("reset_uart_out", 32'(uart_out), 0);
      check("reset_valid", 32'(uart_valid), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      check_idle(2, "post_reset");

      // Basic frame, 10-cycle transmit time.
      send_frame(4'h1, 5'h02, 16'h1234, 16'h00FF, 10, -1, -1, -1);
      // Back-to-back frame started in the cycle after done.
      send_frame(4'h1, 5'h1F, 16'hFFFF, 16'hFFFF, 10, -1, -1, -1);

      // Start while busy at the third byte, plus start during the DONE cycle.
      send_frame(4'h1, 5'h02, 16'h1234, 16'h00FF, 10, 2, -1, -1);
      start = 1'b1; op = 5'h0A;
      @(negedge clk);
      start = 1'b0;
      check("done_start_ignored_busy", 32'(busy), 0);
      check("done_start_ignored_done", 32'(done), 0);
      check_idle(3, "no_extra_frame");

      // Stray tx_done in IDLE and coincident with uart_valid.
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check_idle(1, "idle_stray");
      send_frame(4'h1, 5'h02, 16'h1234, 16'h00FF, 4, -1, 0, -1);
      check_idle(1, "after_stray");

      // Reset during WAIT of B4, then a full frame from A5.
      send_frame(4'h1, 5'h02, 16'h1234, 16'h00FF, 6, -1, -1, 4);
      check_idle(2, "after_rst");
      send_frame(4'h3, 5'h11, 16'hBEEF, 16'h0102, 3, -1, -1, -1);
      check_idle(1, "after_rst_frame");

      // Randomized frames with random gaps and random stray/busy events.
      for (int f = 0; f < 10; f++) begin
         send_frame(4'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(1, 12)),
                    int'($urandom_range(0, NBYTES + 2)),
                    int'($urandom_range(0, NBYTES + 2)), -1);
         if ($urandom_range(0, 1) == 1) check_idle(int'($urandom_range(1, 3)), "rand_gap");
      end
      check_idle(2, "final_idle");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cmd_serializer.md
CMD_SERIALIZER -- requirements
Module: cmd_serializer

Interface
REQ-001 SHALL have parameter: SYNC_BYTE, 8'hA5, first byte of every command frame.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to send one command frame.
REQ-005 SHALL have port: dtype  input  4  data-type field, sampled when start is accepted.
REQ-006 SHALL have port: op  input  5  opcode field, sampled when start is accepted.
REQ-007 SHALL have port: src1  input  16  first operand, sampled when start is accepted.
REQ-008 SHALL have port: src2  input  16  second operand, sampled when start is accepted.
REQ-009 SHALL have port: uart_out  output  8  byte to the UART transmitter.
REQ-010 SHALL have port: uart_valid  output  1  one-cycle pulse; uart_out is valid and the transmit begins.
REQ-011 SHALL have port: tx_done  input  1  one-cycle pulse from the UART when the current byte has left the line.
REQ-012 SHALL have port: busy  output  1  high from start acceptance until done.
REQ-013 SHALL have port: done  output  1  one-cycle pulse when the whole frame has been sent.

Function
REQ-014 SHALL send the frame bytes in this order: B0=SYNC_BYTE, B1={dtype,4'h0}, B2={3'b000,op}, B3=src1[15:8], B4=src1[7:0], B5=src2[15:8], B6=src2[7:0].
REQ-015 SHALL use the FSM states IDLE, SEND, WAIT and DONE.
REQ-016 SHALL, when IDLE and start=1, capture all fields into internal registers, clear the byte index and go to SEND.
REQ-017 SHALL, in SEND, drive uart_out=byte[index] with uart_valid=1 for that one cycle, then go to WAIT.
REQ-018 SHALL, in WAIT, hold uart_out stable; on tx_done, go to DONE if the index is the last byte, otherwise increment the index and go to SEND.
REQ-019 SHALL, in DONE, assert done for that one cycle, then go to IDLE.
REQ-020 SHALL drive busy = (state != IDLE).
REQ-021 SHALL produce this latency: start accepted at cycle N gives the first uart_valid at N+1; the final tx_done at cycle M gives done at M+1.
REQ-022 SHALL ignore start while busy, including the DONE cycle; no queueing.
REQ-023 SHALL ignore tx_done in IDLE, SEND and DONE, including a tx_done coincident with uart_valid.
REQ-024 SHALL not be affected by input field changes after capture.
REQ-025 SHALL accept back-to-back frames: start in the cycle after done is accepted normally.

Reset
REQ-026 SHALL, on n_rst low at any time (including mid-frame), immediately go to IDLE with uart_out=8'h00, uart_valid=0, busy=0, done=0, index=0 and captured fields=0.
REQ-027 SHALL discard any partially sent frame on reset; it is not resumed after release.

Configuration
REQ-028 SHALL, with CMD_CHKSUM_EN defined, append B7 = B1^B2^B3^B4^B5^B6, making the frame 8 bytes.
REQ-029 SHALL, with CMD_CHKSUM_EN undefined, send a 7-byte frame with no checksum logic present.

Structure
REQ-030 SHALL place in shared package cmd_pkg: the state enum, the SYNC_BYTE default, the field widths, and the frame-length constants (7 without and 8 with checksum).
REQ-031 SHALL have no sub-module; byte selection is a package function of index and captured fields.

Verification
REQ-032 SHALL verify the basic frame: dtype=1, op=2, src1=16'h1234, src2=16'h00FF, tx_done 10 cycles after each uart_valid. Required bytes: A5,10,02,12,34,00,FF, then CB when CMD_CHKSUM_EN; done is one pulse one cycle after the last tx_done.
REQ-033 SHALL verify start while busy: second start at the third uart_valid. Required: no extra frame, and the bytes are unchanged.
REQ-034 SHALL verify stray handshakes: tx_done pulsed in IDLE and coincident with uart_valid. Required: no index advance, and frame content and length are unchanged.
REQ-035 SHALL verify reset mid-frame: n_rst low during WAIT of B4. Required: all outputs are 0 immediately; after release, a new start sends a full frame from A5.
REQ-036 SHALL verify back-to-back frames: start in the cycle after done, with op=5'h1F and src1=src2=16'hFFFF. Required: A5,10,1F,FF,FF,FF,FF; checksum 1F^10 = 0F when enabled.
REQ-037 SHALL verify field change after capture: dtype/op/src change the cycle after start. Required: the frame carries the originally captured values.
